pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline-stage register that supersedes the fixed F→D stage latch. It carries PC, payload, branch-delay flag and exception code between any two pipeline stages through a valid/ready handshake with a 2-entry skid buffer, so back-pressure never forms a combinational ready path. An exception request flushes both entries and presents a bubble tagged with the handler PC.

---
 rtl/pipe_stage_buf_if.sv | 15 +
 rtl/pipe_stage_buf.sv | 58 +++++
 tb/tb_pipe_stage_buf.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: valid/ready stage bundle carrying PC, payload, branch-delay flag and exception code.
interface pipe_stage_buf_if #(
  parameter int PC_W = 32,
  parameter int DATA_W = 32,
  parameter int EXC_W = 5
);
  logic valid;
  logic ready;
  logic [PC_W-1:0] pc;
  logic [DATA_W-1:0] data;
  logic bd;
  logic [EXC_W-1:0] exc;
  modport master(output valid, pc, data, bd, exc, input ready);
  modport slave(input valid, pc, data, bd, exc, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline stage with 2-entry skid buffer and flush; define PIPE_STAGE_STALL_CNT_EN to build the stall counter.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int PC_W = 32,
  parameter int EXC_W = 5,
  parameter logic [PC_W-1:0] RESET_PC = 'h0000_3000,
  parameter logic [PC_W-1:0] HANDLER_PC = 'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  pipe_stage_buf_if.slave  up,
  pipe_stage_buf_if.master dn,
  output logic [31:0] stall_cnt
);
  localparam int E_W = PC_W + DATA_W + 1 + EXC_W;
  localparam logic [E_W-1:0] RESET_E = {RESET_PC, {(E_W-PC_W){1'b0}}};
  localparam logic [E_W-1:0] HANDLER_E = {HANDLER_PC, {(E_W-PC_W){1'b0}}};
  logic [1:0] cnt_q, cnt_d;
  logic [E_W-1:0] main_q, main_d, skid_q, skid_d, in_e;
  logic acc, deq;
  assign in_e = {up.pc, up.data, up.bd, up.exc};
  // ready/valid decode only registered occupancy, never the opposite handshake
  assign up.ready = cnt_q != 2'd2;
  assign dn.valid = cnt_q != 2'd0;
  assign {dn.pc, dn.data, dn.bd, dn.exc} = main_q;
  assign acc = up.valid & up.ready;
  assign deq = dn.valid & dn.ready;
  always_comb begin
    cnt_d = flush ? 2'd0 : cnt_q + {1'b0, acc} - {1'b0, deq};
    main_d = flush ? HANDLER_E
           : (acc && (cnt_q == 2'd0 || deq)) ? in_e
           : (deq && cnt_q == 2'd2) ? skid_q : main_q;
    skid_d = flush ? '0 : (acc && !deq && cnt_q == 2'd1) ? in_e : skid_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 2'd0;
      main_q <= RESET_E;
      skid_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  always_comb stall_d = (dn.valid && !dn.ready && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk) begin
    if (!reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: random + directed scoreboard bench; the model is a bounded FIFO of depth 2 with flush.
module tb_pipe_stage_buf;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        bd;
    logic [4:0]  exc;
  } ent_t;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] HND_PC = 32'h0000_4180;
  logic clk = 1'b0;
  logic reset, flush;
  logic [31:0] stall_cnt;
  pipe_stage_buf_if up_if();
  pipe_stage_buf_if dn_if();
  pipe_stage_buf dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .up(up_if.slave),
    .dn(dn_if.master),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  ent_t q[$];
  ent_t idle;
  ent_t exp_e;
  logic [31:0] stall_m = 32'd0;
  bit mon_en = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  function automatic ent_t mk(logic [31:0] pc, logic [31:0] data, logic bd, logic [4:0] exc);
    ent_t e;
    e.pc = pc;
    e.data = data;
    e.bd = bd;
    e.exc = exc;
    return e;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // Issue one cycle of stimulus; the expected entry is queued once the edge that accepts it occurs.
  task automatic step(input bit rn, input bit f, input bit v, input bit r, input ent_t e);
    bit acc, sinc;
    reset = rn;
    flush = f;
    up_if.valid = v;
    up_if.pc = e.pc;
    up_if.data = e.data;
    up_if.bd = e.bd;
    up_if.exc = e.exc;
    dn_if.ready = r;
    acc = v && q.size() < 2;
    sinc = rn && q.size() > 0 && !r;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      idle = mk(RST_PC, 0, 0, 0);
      stall_m = 0;
    end else begin
      if (sinc && stall_m != 32'hFFFF_FFFF) stall_m++;
      if (f) begin
        q.delete();
        idle = mk(HND_PC, 0, 0, 0);
      end else if (acc) q.push_back(e);
    end
    mon_en = 1'b1;
    #1;
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      exp_e = q.size() > 0 ? q[0] : idle;
      chk("in_ready", 64'(up_if.ready), 64'(q.size() < 2));
      chk("out_valid", 64'(dn_if.valid), 64'(q.size() > 0));
      chk("out_pc", 64'(dn_if.pc), 64'(exp_e.pc));
      chk("out_data", 64'(dn_if.data), 64'(exp_e.data));
      chk("out_bd", 64'(dn_if.bd), 64'(exp_e.bd));
      chk("out_exc", 64'(dn_if.exc), 64'(exp_e.exc));
`ifdef PIPE_STAGE_STALL_CNT_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
`else
      chk("stall_cnt", 64'(stall_cnt), 64'd0);
`endif
      if (q.size() > 0 && dn_if.ready && reset && !flush) idle = q.pop_front();
    end
  end
  initial begin
    ent_t z, e;
    z = mk(0, 0, 0, 0);
    step(0, 0, 0, 0, z);
    step(0, 0, 0, 0, z);
    step(1, 0, 0, 0, z);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, mk(32'h3000 + 32'(4 * i), $urandom, 0, 0));
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, z);
    step(1, 0, 1, 0, mk(32'h3000, 32'h11, 0, 0));
    step(1, 0, 1, 0, mk(32'h3004, 32'h22, 0, 0));
    step(1, 0, 1, 0, mk(32'h3008, 32'h33, 0, 0));
    step(1, 0, 0, 0, z);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, z);
    step(1, 0, 1, 0, mk(32'h3010, 32'h44, 0, 0));
    step(1, 0, 1, 0, mk(32'h3014, 32'h55, 1, 5'd3));
    step(1, 1, 1, 1, mk(32'h3018, 32'h66, 0, 0));
    step(1, 0, 0, 1, z);
    step(1, 0, 1, 0, mk(32'h3020, 32'hDEAD_BEEF, 1, 5'd4));
    step(1, 0, 0, 0, z);
    step(1, 0, 0, 1, z);
    step(1, 0, 1, 0, mk(32'h3024, 32'h77, 0, 0));
    step(1, 0, 0, 0, z);
    step(0, 1, 1, 1, mk(32'h3028, 32'h88, 0, 0));
    step(1, 0, 0, 0, z);
    for (int i = 0; i < 400; i++) begin
      e = mk($urandom, $urandom, 1'($urandom), 5'($urandom));
      step($urandom_range(63) != 0, $urandom_range(15) == 0, $urandom_range(3) != 0,
           $urandom_range(2) != 0, e);
    end
    step(1, 0, 0, 1, z);
    step(1, 0, 0, 1, z);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
